// File: rtl/knight_fade.sv
// knight_fade: afterglow stage for the knight LED sequencer.
// Lit LEDs drive full on; unlit LEDs fade out through per-LED PWM.
module knight_fade #(
  parameter int LVL_W     = 4,
  parameter int DECAY_DIV = 16
) (
  input  logic       ck,
  input  logic       res,
  input  logic [7:0] pat_in,
  input  logic       pat_valid,
  output logic [7:0] led_out,
  output logic       frame
);

  localparam int MAX = (1 << LVL_W) - 1;
  localparam int DW  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [LVL_W-1:0] MAX_V  = LVL_W'(MAX);
  localparam logic [LVL_W-1:0] LAST_P = LVL_W'(MAX - 1);
  localparam logic [DW-1:0]    LAST_D = DW'(DECAY_DIV - 1);

  logic [7:0]            pat_q, pat_d;
  logic [7:0][LVL_W-1:0] lvl_q, lvl_d;
  logic [LVL_W-1:0]      pwm_q, pwm_d;
  logic [DW-1:0]         dec_q, dec_d;
  logic [7:0]            led_q, led_d;
  logic                  frame_q, frame_d;

  logic       wrap;
  logic       tick;
  logic [7:0] eff;

  // Frame wrap, decay tick and the pattern currently in force
  always_comb begin
    wrap = (pwm_q == LAST_P);
    tick = wrap && (dec_q == LAST_D);
    eff  = pat_valid ? pat_in : pat_q;
  end

  // Next-state: counters, held pattern, per-LED levels and PWM compare
  always_comb begin
    pwm_d   = wrap ? '0 : pwm_q + LVL_W'(1);
    dec_d   = dec_q;
    if (wrap) begin
      dec_d = (dec_q == LAST_D) ? '0 : dec_q + DW'(1);
    end
    pat_d   = pat_valid ? pat_in : pat_q;
    frame_d = wrap;
    lvl_d   = lvl_q;
    led_d   = '0;
    for (int i = 0; i < 8; i++) begin
      led_d[i] = (lvl_q[i] > pwm_q);
      if (eff[i]) begin
        lvl_d[i] = MAX_V;
      end else if (tick && (lvl_q[i] != '0)) begin
        lvl_d[i] = lvl_q[i] - LVL_W'(1);
      end
    end
  end

  // State register with synchronous reset that overrides any fade
  always_ff @(posedge ck) begin
    if (res) begin
      pat_q   <= '0;
      lvl_q   <= '0;
      pwm_q   <= '0;
      dec_q   <= '0;
      led_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      lvl_q   <= lvl_d;
      pwm_q   <= pwm_d;
      dec_q   <= dec_d;
      led_q   <= led_d;
      frame_q <= frame_d;
    end
  end

  assign led_out = led_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_knight_fade.sv
// tb_knight_fade: directed scenarios plus random patterns,
// checked cycle by cycle against a time-based reference model.
module tb_knight_fade;

  localparam int LW  = 2;
  localparam int DD  = 2;
  localparam int MAX = (1 << LW) - 1;
  localparam int TP  = MAX * DD;

  logic       ck = 1'b0;
  logic       res;
  logic       pat_valid;
  logic [7:0] pat_in;
  logic [7:0] led_out;
  logic       frame;

  int checks = 0;
  int errors = 0;

  int         t;
  int         lvl [8];
  logic [7:0] preg;
  logic [7:0] m_led;
  logic       m_frame;
  bit         chk_en = 1'b0;

  knight_fade #(
    .LVL_W    (LW),
    .DECAY_DIV(DD)
  ) dut (
    .ck       (ck),
    .res      (res),
    .pat_in   (pat_in),
    .pat_valid(pat_valid),
    .led_out  (led_out),
    .frame    (frame)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: t = edges since reset release; phase and tick
  // follow from t by modular arithmetic.
  always @(posedge ck) begin : model
    logic [7:0] eff;
    int p;
    if (res) begin
      t       = 0;
      preg    = '0;
      m_led   = '0;
      m_frame = 1'b0;
      for (int i = 0; i < 8; i++) lvl[i] = 0;
    end else begin
      p       = t % MAX;
      m_frame = (p == MAX - 1);
      for (int i = 0; i < 8; i++) m_led[i] = (lvl[i] > p);
      eff = pat_valid ? pat_in : preg;
      for (int i = 0; i < 8; i++) begin
        if (eff[i]) lvl[i] = MAX;
        else if ((t % TP) == TP - 1 && lvl[i] > 0) lvl[i]--;
      end
      if (pat_valid) preg = pat_in;
      t++;
    end
  end

  always @(negedge ck) begin
    if (chk_en) begin
      chk("led", {24'd0, led_out}, {24'd0, m_led});
      chk("frame", {31'd0, frame}, {31'd0, m_frame});
    end
  end

  task automatic pulse(input logic [7:0] p);
    pat_in    = p;
    pat_valid = 1'b1;
    @(negedge ck);
    pat_valid = 1'b0;
  endtask

  initial begin
    int n;
    int last;
    res       = 1'b1;
    pat_in    = 8'hFF;
    pat_valid = 1'b1;
    @(negedge ck);
    chk_en = 1'b1;
    chk("rst_led0", {24'd0, led_out}, 32'd0);
    @(negedge ck);
    chk("rst_led1", {24'd0, led_out}, 32'd0);
    chk("rst_frm", {31'd0, frame}, 32'd0);
    res       = 1'b0;
    pat_valid = 1'b0;
    pat_in    = 8'h00;

    for (int c = 1; c <= 6; c++) begin
      @(negedge ck);
      chk("frm_seq", {31'd0, frame}, {31'd0, (c % 3 == 0)});
    end

    pulse(8'h01);
    chk("s2_lat", {31'd0, led_out[0]}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge ck);
      chk("s2_on", {24'd0, led_out}, 32'h01);
    end

    pulse(8'h02);
    last = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge ck);
      if (led_out[0]) last = c;
      chk("s3_l1", {31'd0, led_out[1]}, 32'd1);
    end
    chk("s3_fade", {31'd0, (last <= 18)}, 32'd1);

    for (int c = 0; c < 30; c++) begin
      @(negedge ck);
      chk("s5_sat", {31'd0, led_out[0]}, 32'd0);
    end
    pulse(8'h01);
    @(negedge ck);
    chk("s5_relit", {31'd0, led_out[0]}, 32'd1);

    pulse(8'h03);
    pulse(8'h00);
    n = 0;
    while (!(lvl[0] == 2 && (t % TP) == TP - 1) && n < 40) begin
      @(negedge ck);
      n++;
    end
    chk("s4_wait", {31'd0, (n < 40)}, 32'd1);
    pulse(8'h01);
    for (int c = 0; c < 6; c++) begin
      @(negedge ck);
      chk("s4_l0", {31'd0, led_out[0]}, 32'd1);
    end

    pulse(8'h00);
    n = 0;
    while (lvl[0] != 2 && n < 40) begin
      @(negedge ck);
      n++;
    end
    chk("s6_wait", {31'd0, (n < 40)}, 32'd1);
    res = 1'b1;
    @(negedge ck);
    chk("s6_rst", {24'd0, led_out}, 32'd0);
    chk("s6_frm", {31'd0, frame}, 32'd0);
    res = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ck);
      chk("s6_dark", {24'd0, led_out}, 32'd0);
    end

    for (int c = 0; c < 800; c++) begin
      res       = ($urandom % 80) == 0;
      pat_valid = ($urandom % 5) == 0;
      case ($urandom % 4)
        0:       pat_in = 8'($urandom);
        1:       pat_in = 8'h00;
        default: pat_in = 8'(1 << ($urandom % 8));
      endcase
      @(negedge ck);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
